// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NREQ requesters.
// Requests use a valid/ready grant handshake, results return on a valid/ready response channel.
module alu_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 16,
  parameter int ALU_EDGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*4-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_setznl,
  output logic [NREQ-1:0]       req_ready,
  output logic [3:0]            alu_op,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [WIDTH-1:0]      alu_in2,
  output logic                  alu_setznl,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic [1:0]            alu_fc,
  input  logic [2:0]            alu_znl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [1:0]            rsp_fc,
  output logic [2:0]            rsp_znl,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ALU_EDGES + 2);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;

  // Scan from the requester after the last winner, wrapping, so the last winner ranks lowest.
  // NOTE: every variable assigned here gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The grant must be combinational so a request is accepted in the cycle it is offered.
  assign req_ready = (state == IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      cnt        <= '0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_setznl <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_fc     <= '0;
      rsp_znl    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_op     <= req_op[4*grant_idx +: 4];
            alu_in1    <= req_a[WIDTH*grant_idx +: WIDTH];
            alu_in2    <= req_b[WIDTH*grant_idx +: WIDTH];
            alu_setznl <= req_setznl[grant_idx];
            rsp_id     <= 3'(grant_idx);
            ptr        <= grant_idx;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + CW'(1);
          // The ALU's flags lag its result by one edge, so sample only after ALU_EDGES edges.
          if (cnt == CW'(ALU_EDGES)) begin
            rsp_data   <= alu_out;
            rsp_fc     <= alu_fc;
            rsp_znl    <= alu_znl;
            rsp_valid  <= 1'b1;
            alu_op     <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_setznl <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU and a response scoreboard.
module tb_alu_arbiter;

  localparam int NREQ      = 4;
  localparam int W         = 16;
  localparam int ALU_EDGES = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_setznl, req_ready;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [3:0]      alu_op;
  logic [W-1:0]    alu_in1, alu_in2, alu_out;
  logic            alu_setznl;
  logic [1:0]      alu_fc, rsp_fc;
  logic [2:0]      alu_znl, rsp_znl, rsp_id;
  logic            rsp_valid, rsp_ready, busy;
  logic [W-1:0]    rsp_data;

  logic [3:0]      t_op[NREQ];
  logic [W-1:0]    t_a[NREQ], t_b[NREQ];
  logic [NREQ-1:0] t_valid, t_setznl;

  typedef struct {
    logic [2:0]   id;
    logic [W-1:0] data;
    logic [1:0]   fc;
    logic [2:0]   znl;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  sb_fc  = '0;
  logic [2:0]  sb_znl = '0;
  int          tb_ptr;
  int          last_grant;
  logic [W-1:0] last_data;
  logic [1:0]  last_fc;
  logic [2:0]  last_znl;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .ALU_EDGES(ALU_EDGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_setznl(req_setznl), .req_ready(req_ready),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_setznl(alu_setznl),
    .alu_out(alu_out), .alu_fc(alu_fc), .alu_znl(alu_znl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_fc(rsp_fc), .rsp_znl(rsp_znl), .busy(busy)
  );

  assign req_valid  = t_valid;
  assign req_setznl = t_setznl;
  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[4*i +: 4] = t_op[i];
      req_a[W*i +: W]  = t_a[i];
      req_b[W*i +: W]  = t_b[i];
    end
  end

  function automatic logic [W-1:0] alu_res(input logic [3:0] op, input logic [W-1:0] a, b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] alu_fc_of(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W:0] s;
    if (op == 4'd3) begin
      s = {1'b0, a} + {1'b0, b};
      return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s[W]};
    end
    s = {1'b0, a - b};
    return {(a[W-1] != b[W-1]) && (s[W-1] != a[W-1]), a < b};
  endfunction

  // Registered ALU: result on the first edge, N/Z taken from the previous result on later edges.
  logic [W-1:0] m_out = '0;
  logic         m_lt  = 1'b0;
  logic [1:0]   m_fc  = '0;
  logic [2:0]   m_znl = '0;
  always @(posedge clk) begin
    m_out <= alu_res(alu_op, alu_in1, alu_in2);
    m_lt  <= $signed(alu_in1) < $signed(alu_in2);
    if (alu_op == 4'd3 || alu_op == 4'd4) m_fc <= alu_fc_of(alu_op, alu_in1, alu_in2);
    if (alu_setznl) m_znl <= {m_out[W-1], m_out == '0, m_lt};
  end
  assign alu_out = m_out;
  assign alu_fc  = m_fc;
  assign alu_znl = m_znl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int rr_next(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, b, input logic s);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_setznl[i] = s;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {req_ready, alu_op, alu_in1, alu_in2, alu_setznl, busy}, '0);
    check({tag, "_b"}, {rsp_valid, rsp_id, rsp_data, rsp_fc, rsp_znl}, '0);
  endtask

  // Called at a falling edge with the DUT idle; runs one transaction through the response handshake.
  task automatic txn(input int hold);
    int g, waited;
    exp_t e;
    logic [3:0] op_l;
    logic [W-1:0] a_l, b_l;
    logic s_l;
    logic [NREQ-1:0] rdy_exp;
    g = rr_next(t_valid, tb_ptr);
    op_l = t_op[g]; a_l = t_a[g]; b_l = t_b[g]; s_l = t_setznl[g];
    rdy_exp = NREQ'(1) << g;
    #1 check("grant", req_ready, rdy_exp);
    e.id   = 3'(g);
    e.data = alu_res(op_l, a_l, b_l);
    if (op_l == 4'd3 || op_l == 4'd4) sb_fc = alu_fc_of(op_l, a_l, b_l);
    if (s_l) sb_znl = {e.data[W-1], e.data == '0, $signed(a_l) < $signed(b_l)};
    e.fc  = sb_fc;
    e.znl = sb_znl;
    sb.push_back(e);
    tb_ptr = g;
    last_grant = g;
    for (int k = 0; k <= ALU_EDGES; k++) begin
      @(negedge clk);
      check("exec_drive", {alu_op, alu_setznl, alu_in1, alu_in2, rsp_valid, busy, req_ready},
            {op_l, s_l, a_l, b_l, 1'b0, 1'b1, 4'b0});
    end
    @(negedge clk);
    check("rsp_latency", rsp_valid, 1'b1);
    waited = 0;
    while (!rsp_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("bp_stable", {rsp_valid, busy, req_ready, rsp_id, rsp_data, rsp_fc, rsp_znl},
            {1'b1, 1'b1, 4'b0, e.id, e.data, e.fc, e.znl});
      @(negedge clk);
    end
    check("rsp_id", rsp_id, e.id);
    check("rsp_data", rsp_data, e.data);
    check("rsp_flags", {rsp_fc, rsp_znl}, {e.fc, e.znl});
    last_data = rsp_data; last_fc = rsp_fc; last_znl = rsp_znl;
    rsp_ready = 1'b1;
    #1 check("hs_no_grant", req_ready, 4'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_release", {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    t_valid = '0;
    t_setznl = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, '0, '0, 1'b0);
    tb_ptr = NREQ - 1;

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single ADD with signed overflow
    set_req(0, 4'd3, 16'h7FFF, 16'h0001, 1'b0);
    t_valid = 4'b0001;
    txn(0);
    t_valid = '0;
    check("t1_id", last_grant, 0);
    check("t1_result", {last_data, last_fc}, {16'h8000, 2'b10});

    // SUB updating ZNL
    set_req(2, 4'd4, 16'd3, 16'd5, 1'b1);
    t_valid = 4'b0100;
    txn(0);
    t_valid = '0;
    check("t2_id", last_grant, 2);
    check("t2_result", {last_data, last_fc[0], last_znl}, {16'hFFFE, 1'b1, 3'b101});

    // Round-robin with all four requesters holding valid, including an out-of-range opcode
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset2");
    rst_n = 1'b1;
    tb_ptr = NREQ - 1;
    set_req(0, 4'd0, 16'hF0F0, 16'hFF00, 1'b1);
    set_req(1, 4'd1, 16'h00F0, 16'h0F00, 1'b0);
    set_req(2, 4'd2, 16'h5A5A, 16'h5A5A, 1'b1);
    set_req(3, 4'hF, 16'h1234, 16'h0001, 1'b1);
    t_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      txn(0);
      check("rr_order", last_grant, order[i]);
      if (i == 3) check("oor_result", last_data, 16'h0000);
    end
    t_valid = '0;

    // Backpressure, then the same lone requester is granted again
    set_req(1, 4'd4, 16'd100, 16'd100, 1'b1);
    t_valid = 4'b0010;
    txn(10);
    txn(0);
    check("single_again", last_grant, 1);
    t_valid = '0;

    // Reset during the second EXEC cycle drops the transaction
    set_req(3, 4'd2, 16'd5, 16'd5, 1'b0);
    t_valid = 4'b1000;
    #1 check("t5_grant", req_ready, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    t_valid = '0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    check("no_rsp_in_reset", rsp_valid, 1'b0);
    rst_n = 1'b1;
    tb_ptr = NREQ - 1;
    set_req(0, 4'd3, 16'hFFFF, 16'h0001, 1'b1);
    t_valid = 4'b0101;
    txn(0);
    check("t5_first", last_grant, 0);
    check("t5_result", {last_data, last_fc, last_znl}, {16'h0000, 2'b01, 3'b011});
    t_valid = '0;

    // Idle: ALU held at AND with zero operands and no flag updates
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_drive", {alu_op, alu_setznl, alu_in1, alu_in2, busy, rsp_valid, req_ready}, '0);
    end
    check("idle_flags", {alu_fc, alu_znl}, {sb_fc, sb_znl});
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
